// File: rtl/bldc_pkg.sv
// Shared definitions for the BLDC commutation controller: hall sectors,
// FSM encoding, fault codes, hall decode and the (dir, sector) gate table.
// Gate vector bit order is {gha, gla, ghb, glb, ghc, glc}.
package bldc_pkg;

  localparam logic [2:0] SEC_A       = 3'd0;
  localparam logic [2:0] SEC_B       = 3'd1;
  localparam logic [2:0] SEC_C       = 3'd2;
  localparam logic [2:0] SEC_D       = 3'd3;
  localparam logic [2:0] SEC_E       = 3'd4;
  localparam logic [2:0] SEC_F       = 3'd5;
  localparam logic [2:0] SEC_INVALID = 3'd7;

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_DEADTIME = 2'd1,
    ST_DRIVE    = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE   = 2'd0;
  localparam logic [1:0] FC_DRIVER = 2'd1;
  localparam logic [1:0] FC_STALL  = 2'd2;

  // Hall code {h1,h2,h3} to electrical sector; 000 and 111 are not legal.
  function automatic logic [2:0] hall_to_sector(input logic [2:0] code);
    case (code)
      3'b101:  return SEC_A;
      3'b100:  return SEC_B;
      3'b110:  return SEC_C;
      3'b010:  return SEC_D;
      3'b011:  return SEC_E;
      3'b001:  return SEC_F;
      default: return SEC_INVALID;
    endcase
  endfunction

  function automatic logic [2:0] sector_next(input logic [2:0] s);
    return (s == SEC_F) ? SEC_A : s + 3'd1;
  endfunction

  function automatic logic [2:0] sector_prev(input logic [2:0] s);
    return (s == SEC_A) ? SEC_F : s - 3'd1;
  endfunction

  // One high side and one low side on different phases, never both on a phase.
  function automatic logic [5:0] gate_vector(input logic dir, input logic [2:0] sector);
    logic [5:0] g;
    g = 6'b000000;
    if (dir) begin
      case (sector)
        SEC_A:   g = 6'b000110; // HC + LB
        SEC_B:   g = 6'b100100; // HA + LB
        SEC_C:   g = 6'b100001; // HA + LC
        SEC_D:   g = 6'b001001; // HB + LC
        SEC_E:   g = 6'b011000; // HB + LA
        SEC_F:   g = 6'b010010; // HC + LA
        default: g = 6'b000000;
      endcase
    end else begin
      case (sector)
        SEC_A:   g = 6'b001001; // HB + LC
        SEC_B:   g = 6'b011000; // HB + LA
        SEC_C:   g = 6'b010010; // HC + LA
        SEC_D:   g = 6'b000110; // HC + LB
        SEC_E:   g = 6'b100100; // HA + LB
        SEC_F:   g = 6'b100001; // HA + LC
        default: g = 6'b000000;
      endcase
    end
    return g;
  endfunction

endpackage

// File: rtl/bldc_commutation_controller_hall_filter.sv
// Hall input conditioner: 2-FF synchroniser plus stability counter.
// Latency: new code accepted HALL_FILTER cycles after it leaves the synchroniser.
// No backpressure; `changed` is a one-cycle strobe on each accepted code.
module hall_filter
  import bldc_pkg::*;
#(
  parameter int HALL_FILTER = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] hall_raw,
  output logic [2:0] code,
  output logic       changed
);

  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] cand;
  logic [7:0] cnt;
  logic [7:0] cnt_next;
  logic       code_valid;

  // Run length of the current synchronised code, counting this cycle.
  always_comb cnt_next = (sync2 == cand) ? cnt + 8'd1 : 8'd1;

  // Synchronise, then accept a differing code once it has been stable long enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 3'b000;
      sync2      <= 3'b000;
      cand       <= 3'b000;
      cnt        <= 8'd0;
      code       <= 3'b000;
      code_valid <= 1'b0;
      changed    <= 1'b0;
    end else begin
      sync1   <= hall_raw;
      sync2   <= sync1;
      cand    <= sync2;
      changed <= 1'b0;
      if (code_valid && (sync2 == code)) begin
        cnt <= 8'd0;
      end else if (cnt_next >= 8'(HALL_FILTER)) begin
        code       <= sync2;
        code_valid <= 1'b1;
        changed    <= 1'b1;
        cnt        <= 8'd0;
      end else begin
        cnt <= cnt_next;
      end
    end
  end

endmodule

// File: rtl/bldc_commutation_controller.sv
// Three-phase gate sequencer with dead time, fault latch and signed step count.
// Latency: hall pin change to gates off is 2 + HALL_FILTER + 1 cycles.
// No backpressure. Optional stall detection under macro BLDC_STALL_DETECT_EN.
module bldc_commutation_controller
  import bldc_pkg::*;
#(
  parameter int DEADTIME_CYCLES = 1024,
  parameter int HALL_FILTER     = 16,
  parameter int STALL_CYCLES    = 16_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               dir,
  input  logic               hall1,
  input  logic               hall2,
  input  logic               hall3,
  input  logic               fault_n,
  input  logic               fault_clear,
  output logic               gha,
  output logic               gla,
  output logic               ghb,
  output logic               glb,
  output logic               ghc,
  output logic               glc,
  output logic [2:0]         commutation_state,
  output logic               hall_error,
  output logic               step_pulse,
  output logic signed [31:0] step_count,
  output logic               fault,
  output logic [1:0]         fault_code
);

  localparam logic [15:0] DT_LOAD = 16'(DEADTIME_CYCLES - 1);

  state_t      state;
  logic [15:0] dt_cnt;
  logic [5:0]  gates;
  logic [2:0]  hall_code;
  logic        hall_chg;
  logic [2:0]  new_sector;
  logic        sector_chg;
  logic        dir_q;
  logic        dir_chg;
  logic        fault_s1;
  logic        fault_s2;
  logic        stall_hit;

  hall_filter #(.HALL_FILTER(HALL_FILTER)) u_hall_filter (
    .clk      (clk),
    .reset    (reset),
    .hall_raw ({hall1, hall2, hall3}),
    .code     (hall_code),
    .changed  (hall_chg)
  );

  assign new_sector = hall_to_sector(hall_code);
  assign sector_chg = hall_chg && (new_sector != commutation_state);
  assign dir_chg    = (dir != dir_q);
  assign {gha, gla, ghb, glb, ghc, glc} = gates;

  // Previous dir for change detection; tracks the pin even during reset.
  always_ff @(posedge clk) dir_q <= dir;

  // Synchronise the asynchronous driver fault; idle level is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_s1 <= 1'b1;
      fault_s2 <= 1'b1;
    end else begin
      fault_s1 <= fault_n;
      fault_s2 <= fault_s1;
    end
  end

`ifdef BLDC_STALL_DETECT_EN
  logic [23:0] stall_cnt;

  assign stall_hit = (state == ST_DRIVE) && !hall_chg && (stall_cnt == 24'(STALL_CYCLES - 1));

  // Cycles spent in DRIVE since the last accepted hall change.
  always_ff @(posedge clk) begin
    if (reset || (state != ST_DRIVE) || hall_chg) stall_cnt <= 24'd0;
    else                                         stall_cnt <= stall_cnt + 24'd1;
  end
`else
  // Never true for a legal STALL_CYCLES; stall detection is not built.
  assign stall_hit = (STALL_CYCLES < 0);
`endif

  // Sector register, hall error flag and signed step accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      commutation_state <= SEC_INVALID;
      hall_error        <= 1'b0;
      step_pulse        <= 1'b0;
      step_count        <= 32'sd0;
    end else begin
      step_pulse <= 1'b0;
      if (hall_chg) begin
        commutation_state <= new_sector;
        hall_error        <= (new_sector == SEC_INVALID);
        if ((commutation_state != SEC_INVALID) && (new_sector != SEC_INVALID)) begin
          if (new_sector == sector_next(commutation_state)) begin
            step_count <= step_count + 32'sd1;
            step_pulse <= 1'b1;
          end else if (new_sector == sector_prev(commutation_state)) begin
            step_count <= step_count - 32'sd1;
            step_pulse <= 1'b1;
          end
        end
      end
    end
  end

  // Commutation FSM with registered gates; a driver fault overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_OFF;
      dt_cnt     <= 16'd0;
      gates      <= 6'b000000;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else if (!fault_s2) begin
      state      <= ST_FAULT;
      gates      <= 6'b000000;
      fault      <= 1'b1;
      fault_code <= FC_DRIVER;
    end else begin
      case (state)
        ST_OFF: begin
          gates <= 6'b000000;
          if (enable) begin
            state  <= ST_DEADTIME;
            dt_cnt <= DT_LOAD;
          end
        end
        ST_DEADTIME: begin
          gates <= 6'b000000;
          if (!enable) begin
            state <= ST_OFF;
          end else if (sector_chg || dir_chg) begin
            dt_cnt <= DT_LOAD;
          end else if (dt_cnt == 16'd0) begin
            state <= ST_DRIVE;
            gates <= gate_vector(dir, commutation_state);
          end else begin
            dt_cnt <= dt_cnt - 16'd1;
          end
        end
        ST_DRIVE: begin
          if (!enable) begin
            state <= ST_OFF;
            gates <= 6'b000000;
          end else if (stall_hit) begin
            state      <= ST_FAULT;
            gates      <= 6'b000000;
            fault      <= 1'b1;
            fault_code <= FC_STALL;
          end else if (dir_chg || (sector_chg && (new_sector != SEC_INVALID))) begin
            state  <= ST_DEADTIME;
            dt_cnt <= DT_LOAD;
            gates  <= 6'b000000;
          end else if (sector_chg) begin
            // Dropping into an invalid code: nothing safe to drive, stay put.
            gates <= 6'b000000;
          end else begin
            gates <= gate_vector(dir, commutation_state);
          end
        end
        default: begin
          gates <= 6'b000000;
          if (fault_clear) begin
            state      <= ST_OFF;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bldc_commutation_controller.sv
// Scoreboard bench: stimulus pushes expected step events, a monitor pops them
// on every step_pulse and checks gates for shoot-through every cycle.
`timescale 1ns/1ps
module tb_bldc_commutation_controller;

  localparam int DT    = 1024;
  localparam int HF    = 16;
  localparam int STALL = 5000;

  logic clk = 1'b0;
  logic reset, enable, dir, hall1, hall2, hall3, fault_n, fault_clear;
  logic gha, gla, ghb, glb, ghc, glc;
  logic [2:0] commutation_state;
  logic hall_error, step_pulse, fault;
  logic signed [31:0] step_count;
  logic [1:0] fault_code;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] sector;
    int         count;
  } exp_t;
  exp_t exp_q[$];

  int model_sector = 7;
  int model_count  = 0;

  // Sector index -> hall code {h1,h2,h3}
  logic [2:0] sector_code [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
  // Phase indices (0=A,1=B,2=C) of the driven high and low sides per sector
  int fwd_hi [6] = '{2, 0, 0, 1, 1, 2};
  int fwd_lo [6] = '{1, 1, 2, 2, 0, 0};
  int rev_hi [6] = '{1, 1, 2, 2, 0, 0};
  int rev_lo [6] = '{2, 0, 0, 1, 1, 2};

  wire [5:0] gates = {gha, gla, ghb, glb, ghc, glc};

  always #5 clk = ~clk;

  bldc_commutation_controller #(
    .DEADTIME_CYCLES(DT),
    .HALL_FILTER    (HF),
    .STALL_CYCLES   (STALL)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .dir              (dir),
    .hall1            (hall1),
    .hall2            (hall2),
    .hall3            (hall3),
    .fault_n          (fault_n),
    .fault_clear      (fault_clear),
    .gha              (gha),
    .gla              (gla),
    .ghb              (ghb),
    .glb              (glb),
    .ghc              (ghc),
    .glc              (glc),
    .commutation_state(commutation_state),
    .hall_error       (hall_error),
    .step_pulse       (step_pulse),
    .step_count       (step_count),
    .fault            (fault),
    .fault_code       (fault_code)
  );

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int tb_sector(input logic [2:0] c);
    for (int i = 0; i < 6; i++) if (sector_code[i] == c) return i;
    return 7;
  endfunction

  function automatic logic [5:0] exp_gates(input logic d, input int s);
    logic [5:0] g;
    int hi, lo;
    g = 6'b000000;
    if (s > 5) return g;
    hi = d ? fwd_hi[s] : rev_hi[s];
    lo = d ? fwd_lo[s] : rev_lo[s];
    g[5 - 2*hi] = 1'b1;
    g[4 - 2*lo] = 1'b1;
    return g;
  endfunction

  // Drive a hall code held long enough to be accepted; record expected step.
  task automatic set_hall(input logic [2:0] c);
    int s, delta;
    exp_t e;
    {hall1, hall2, hall3} = c;
    s = tb_sector(c);
    if (model_sector < 6 && s < 6) begin
      delta = (s - model_sector + 6) % 6;
      if (delta == 1 || delta == 5) begin
        model_count += (delta == 1) ? 1 : -1;
        e.sector = 3'(s);
        e.count  = model_count;
        exp_q.push_back(e);
      end
    end
    model_sector = s;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Edges until the gates are (nonzero ? on : all off), capped at bound.
  task automatic edges_until(input bit nonzero, input int bound, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((((gates != 6'b0) ? 1'b1 : 1'b0) != nonzero) && n < bound);
  endtask

  // Monitor: shoot-through every cycle, scoreboard pop on each step pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      checks++;
      if ((gha && gla) || (ghb && glb) || (ghc && glc)) begin
        failures++;
        $display("FAIL shoot_through: got gates=%b expected no phase with both sides on", gates);
      end
      if (step_pulse) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_step_pulse: got pulse at sector %0d expected none", commutation_state);
        end else begin
          e = exp_q.pop_front();
          check("step_sector", commutation_state, e.sector);
          check("step_count", step_count, e.count);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    failures++;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, offc, s;
    logic [2:0] c;
    reset = 1'b1; enable = 1'b0; dir = 1'b1; fault_n = 1'b1; fault_clear = 1'b0;
    set_hall(3'b100);
    tick(4);
    check("rst_gates", gates, 0);
    check("rst_state", commutation_state, 7);
    check("rst_step_count", step_count, 0);
    check("rst_fault", fault, 0);
    check("rst_fault_code", fault_code, 0);
    check("rst_hall_error", hall_error, 0);
    check("rst_step_pulse", step_pulse, 0);

    // Start-up: sync + filter + decode + dead time before first drive
    reset = 1'b0; enable = 1'b1;
    edges_until(1'b1, 3000, n);
    check("startup_gap", n, 2 + HF + 1 + DT);
    check("startup_gates", gates, exp_gates(1'b1, 1));
    check("startup_state", commutation_state, 1);

    // Forward rotation through all six sectors
    for (int i = 0; i < 6; i++) begin
      s = (2 + i) % 6;
      set_hall(sector_code[s]);
      edges_until(1'b0, 200, n);
      check("commutate_off_latency", n, 2 + HF + 1);
      edges_until(1'b1, 3000, n);
      check("deadtime_gap", n, DT);
      check("drive_gates", gates, exp_gates(1'b1, s));
      tick(2000 - (2 + HF + 1) - DT);
    end
    check("fwd_step_count", step_count, 6);

    // Short glitch must be rejected by the filter
    offc = 0;
    {hall1, hall2, hall3} = 3'b110;
    for (int i = 0; i < 10; i++) begin tick(1); if (gates == 6'b0) offc++; end
    {hall1, hall2, hall3} = 3'b100;
    for (int i = 0; i < 40; i++) begin tick(1); if (gates == 6'b0) offc++; end
    check("glitch_no_deadtime", offc, 0);
    check("glitch_state", commutation_state, 1);
    check("glitch_step_count", step_count, model_count);

    // Driver fault, clear while still low, then clean recovery
    fault_n = 1'b0;
    edges_until(1'b0, 20, n);
    check("fault_latency", n, 3);
    check("fault_flag", fault, 1);
    check("fault_code_driver", fault_code, 1);
    fault_clear = 1'b1; tick(1); fault_clear = 1'b0;
    tick(3);
    check("fault_held_while_low", fault, 1);
    fault_n = 1'b1;
    tick(4);
    check("fault_held_no_clear", fault, 1);
    fault_clear = 1'b1; tick(1); fault_clear = 1'b0;
    check("fault_cleared", fault, 0);
    check("fault_code_cleared", fault_code, 0);
    edges_until(1'b1, 3000, n);
    check("fault_recover_gap", n, DT + 1);
    check("fault_recover_gates", gates, exp_gates(1'b1, 1));

    // Direction reversal in sector C, then an invalid hall code
    set_hall(sector_code[2]);
    edges_until(1'b0, 200, n);
    edges_until(1'b1, 3000, n);
    dir = 1'b0;
    edges_until(1'b0, 20, n);
    check("dir_off_latency", n, 1);
    edges_until(1'b1, 3000, n);
    check("dir_gap", n, DT);
    check("dir_rev_gates", gates, exp_gates(1'b0, 2));
    set_hall(3'b111);
    tick(HF + 8);
    check("invalid_hall_error", hall_error, 1);
    check("invalid_state", commutation_state, 7);
    check("invalid_gates", gates, 0);

    // Randomised hall codes and direction changes
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) dir = ~dir;
      c = 3'($urandom_range(0, 7));
      set_hall(c);
      if (i % 4 == 3) begin
        tick(DT + HF + 40);
        check("rand_drive_gates", gates, exp_gates(dir, model_sector));
        check("rand_hall_error", hall_error, (model_sector > 5) ? 1 : 0);
      end else begin
        tick($urandom_range(HF + 4, 60));
      end
    end
    tick(HF + 8);
    check("rand_step_count", step_count, model_count);

    // Frozen halls in DRIVE
    s = (model_sector < 6) ? (model_sector + 3) % 6 : 0;
    set_hall(sector_code[s]);
    edges_until(1'b1, 3000, n);
`ifdef BLDC_STALL_DETECT_EN
    edges_until(1'b0, STALL + 200, n);
    check("stall_time", n, STALL);
    check("stall_fault", fault, 1);
    check("stall_fault_code", fault_code, 2);
`else
    tick(STALL + 500);
    check("no_stall_fault", fault, 0);
    check("no_stall_fault_code", fault_code, 0);
    check("no_stall_gates", gates, exp_gates(dir, s));
`endif

    tick(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
